clk_div_sched: RTL and testbench

CLK_DIV_SCHED -- requirements
Module: clk_div_sched

---
 rtl/clk_div_pkg.sv | 19 +
 rtl/div_counter.sv | 51 +++++
 rtl/clk_div_sched.sv | 159 +++++++++++++++
 tb/tb_clk_div_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Purpose : shared types and constants for the clock-divider scheduler.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: CNT_W_DEF  - default width of the ratio and counter fields
//           state_e    - scheduler states IDLE / RUN / SWITCH
package clk_div_pkg;

   localparam int CNT_W_DEF = 8;

   // IDLE   : divider stopped, counter parked at 0, div_clk low
   // RUN    : counting with cur_div, ratio changes accepted
   // SWITCH : a new ratio is pending and is applied at the next period boundary
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      SWITCH = 2'd2
   } state_e;

endpackage

// File: rtl/div_counter.sv
// Purpose : wrap counter 0..max-1 with terminal-count flag for the divider.
// Latency : tc is combinational from the count register; count updates each clock edge.
// Backpressure: none; clr has priority over en, en=0 holds the count.
// Ports   : clock/reset - system clock, async active-high reset
//           clr         - synchronous clear to 0
//           en          - advance (and qualify tc)
//           max         - wrap modulus, must be >= 1
//           cnt         - current count
//           tc          - en && cnt == max-1 (last cycle of a period)
module div_counter
   import clk_div_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] max,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             last;

   // max >= 1 is guaranteed by the scheduler, so max-1 never underflows and
   // cnt_q+1 is only taken while cnt_q < max-1, so it never overflows either.
   assign last = (cnt_q == (max - CNT_W'(1)));
   assign tc   = en && last;
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = last ? '0 : (cnt_q + CNT_W'(1));
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/clk_div_sched.sv
// Purpose : programmable clock divider producing a clk_en pulse every N clocks and
//           a 50% div_clk at clock/(2N), with glitch-free ratio changes.
// Latency : first clk_en N cycles after enable is sampled; new ratio in RUN takes
//           effect at the next period boundary.
// Backpressure: cfg_ready drops while a ratio change is pending (SWITCH state).
// Ports   : clock/reset           - system clock, async active-high reset
//           enable                - run request
//           cfg_valid/cfg_div     - ratio offer, taken when cfg_ready is high
//           cfg_ready             - ratio can be accepted (IDLE or RUN)
//           cfg_err               - one-cycle pulse after a ratio of 0 was accepted
//           clk_en                - one-cycle enable every cur_div clocks
//           div_clk               - registered divided clock, toggles on clk_en
//           cur_div               - ratio in effect
//           busy                  - high in RUN or SWITCH
module clk_div_sched
   import clk_div_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DEF_DIV = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_en,
   output logic             div_clk,
   output logic [CNT_W-1:0] cur_div,
   output logic             busy
);

   localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);

   state_e           state_q,   state_d;
   logic [CNT_W-1:0] cur_div_q, cur_div_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   logic             div_clk_q, div_clk_d;
   logic             cfg_err_q, cfg_err_d;

   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_tc;
   logic [CNT_W-1:0] cnt_unused;

   logic             xfer;
   logic             legal;

   assign busy      = (state_q != IDLE);
   assign cfg_ready = (state_q != SWITCH);
   assign cfg_err   = cfg_err_q;
   assign div_clk   = div_clk_q;
   assign cur_div   = cur_div_q;

   assign xfer  = cfg_valid && cfg_ready;
   assign legal = (cfg_div != '0);

   // The counter only advances while the divider is active, so its terminal
   // count is already qualified by state and can drive clk_en directly.
   assign cnt_en = busy;
   assign clk_en = cnt_tc;

   div_counter #(
      .CNT_W (CNT_W)
   ) u_div_counter (
      .clock (clock),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .max   (cur_div_q),
      .cnt   (cnt_unused),
      .tc    (cnt_tc)
   );

   always_comb begin
      state_d    = state_q;
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      div_clk_d  = div_clk_q;
      cnt_clr    = 1'b0;
      // A zero ratio is swallowed; only the error pulse records it.
      cfg_err_d  = xfer && !legal;

      case (state_q)
         IDLE: begin
            cnt_clr   = 1'b1;
            div_clk_d = 1'b0;
            // Ratio loaded here is in force for the very first count when
            // enable rises on the same edge.
            if (xfer && legal) begin
               cur_div_d = cfg_div;
            end
            if (enable) begin
               state_d = RUN;
            end
         end

         RUN: begin
            if (!enable) begin
               // Stop wins over a coincident clk_en: no final toggle.
               state_d   = IDLE;
               cnt_clr   = 1'b1;
               div_clk_d = 1'b0;
               if (xfer && legal) begin
                  cur_div_d = cfg_div;
               end
            end else begin
               if (cnt_tc) begin
                  div_clk_d = ~div_clk_q;
               end
               // Hold the new ratio until a period boundary so no div_clk
               // phase is ever cut short.
               if (xfer && legal) begin
                  pend_div_d = cfg_div;
                  state_d    = SWITCH;
               end
            end
         end

         SWITCH: begin
            if (!enable) begin
               state_d   = IDLE;
               cnt_clr   = 1'b1;
               div_clk_d = 1'b0;
               cur_div_d = pend_div_q;
            end else if (cnt_tc) begin
               cur_div_d = pend_div_q;
               cnt_clr   = 1'b1;
               div_clk_d = ~div_clk_q;
               state_d   = RUN;
            end
         end

         default: begin
            state_d   = IDLE;
            cnt_clr   = 1'b1;
            div_clk_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cur_div_q  <= DEF_DIV_V;
         pend_div_q <= DEF_DIV_V;
         div_clk_q  <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_div_q  <= cur_div_d;
         pend_div_q <= pend_div_d;
         div_clk_q  <= div_clk_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

endmodule

// File: tb/tb_clk_div_sched.sv
// Purpose : self-checking bench for clk_div_sched; a timeline-based reference model
//           pushes expected outputs per cycle, a monitor pops and compares.
// Latency : model expectation for the cycle after each edge, checked at the negedge.
// Backpressure: model honours cfg_ready by tracking a pending ratio.
`timescale 1ns/1ps
module tb_clk_div_sched;

   localparam int W   = 8;
   localparam int DEF = 1;

   logic         clock;
   logic         reset;
   logic         enable;
   logic         cfg_valid;
   logic [W-1:0] cfg_div;
   logic         cfg_ready;
   logic         cfg_err;
   logic         clk_en;
   logic         div_clk;
   logic [W-1:0] cur_div;
   logic         busy;

   int n_chk  = 0;
   int n_pass = 0;

   clk_div_sched #(
      .CNT_W   (W),
      .DEF_DIV (DEF)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .clk_en    (clk_en),
      .div_clk   (div_clk),
      .cur_div   (cur_div),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // The divider is described as a schedule: while running, the next clk_en edge
   // is an absolute edge number; each tick reschedules it ratio edges later.
   typedef struct {
      logic         clk_en;
      logic         div_clk;
      logic         cfg_ready;
      logic         cfg_err;
      logic         busy;
      logic [W-1:0] cur_div;
   } exp_t;

   exp_t exp_q[$];

   int           edge_no   = 0;
   int           tick_edge = 0;
   bit           m_run     = 0;
   bit           m_sw      = 0;
   bit           m_dclk    = 0;
   bit           m_err     = 0;
   logic [W-1:0] m_ratio   = W'(DEF);
   logic [W-1:0] m_pend    = W'(DEF);
   bit           sw0, xf, lg, tk;
   exp_t         nx;

   always @(posedge clock) begin
      edge_no++;
      if (reset) begin
         m_run   = 0;
         m_sw    = 0;
         m_dclk  = 0;
         m_err   = 0;
         m_ratio = W'(DEF);
         m_pend  = W'(DEF);
      end else begin
         sw0   = m_sw;
         xf    = cfg_valid && !sw0;
         lg    = (cfg_div != 0);
         m_err = xf && !lg;
         tk    = m_run && (edge_no == tick_edge);
         if (!m_run) begin
            m_dclk = 0;
            if (xf && lg) m_ratio = cfg_div;
            if (enable) begin
               m_run     = 1;
               tick_edge = edge_no + int'(m_ratio);
            end
         end else if (!enable) begin
            m_run  = 0;
            m_dclk = 0;
            if (sw0) m_ratio = m_pend;
            else if (xf && lg) m_ratio = cfg_div;
            m_sw = 0;
         end else begin
            if (tk) begin
               m_dclk = !m_dclk;
               if (sw0) begin
                  m_ratio = m_pend;
                  m_sw    = 0;
               end
               tick_edge = edge_no + int'(m_ratio);
            end
            if (xf && lg) begin
               m_pend = cfg_div;
               m_sw   = 1;
            end
         end
      end
      nx.clk_en    = m_run && (edge_no + 1 == tick_edge);
      nx.div_clk   = m_dclk;
      nx.cfg_ready = !m_sw;
      nx.cfg_err   = m_err;
      nx.busy      = m_run;
      nx.cur_div   = m_ratio;
      exp_q.push_back(nx);
   end

   // ---------------- monitor ----------------
   exp_t ex;
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         ex = exp_q.pop_front();
         chk("clk_en",    32'(clk_en),    32'(ex.clk_en));
         chk("div_clk",   32'(div_clk),   32'(ex.div_clk));
         chk("cfg_ready", 32'(cfg_ready), 32'(ex.cfg_ready));
         chk("cfg_err",   32'(cfg_err),   32'(ex.cfg_err));
         chk("busy",      32'(busy),      32'(ex.busy));
         chk("cur_div",   32'(cur_div),   32'(ex.cur_div));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input logic en, input logic v, input logic [W-1:0] d);
      enable    = en;
      cfg_valid = v;
      cfg_div   = d;
      @(posedge clock);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
      chk({tag, "_cfg_err"},   32'(cfg_err),   32'd0);
      chk({tag, "_clk_en"},    32'(clk_en),    32'd0);
      chk({tag, "_div_clk"},   32'(div_clk),   32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_cur_div"},   32'(cur_div),   32'(DEF));
   endtask

   // Returns at the negedge of a cycle where clk_en is high.
   task automatic wait_clk_en(input string tag);
      bit found;
      found = 0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clock);
         if (clk_en) found = 1;
      end
      if (!found) chk({tag, "_clk_en_timeout"}, 32'd0, 32'd1);
   endtask

   // Measures spacing of two div_clk rising edges, sampled at negedges.
   task automatic measure_period(input string tag, input int exp_ns);
      int  seen;
      bit  prev;
      time t0;
      seen = 0;
      t0   = 0;
      prev = div_clk;
      for (int i = 0; i < 80 && seen < 2; i++) begin
         @(negedge clock);
         if (div_clk && !prev) begin
            if (seen == 1) chk({tag, "_period_ns"}, 32'($time - t0), 32'(exp_ns));
            else t0 = $time;
            seen++;
         end
         prev = div_clk;
      end
      if (seen < 2) chk({tag, "_period_timeout"}, 32'd0, 32'd1);
      @(posedge clock);
      #1;
   endtask

   task automatic reset_pulse();
      @(negedge clock);
      #1 reset = 1'b1;
      #1 check_reset_vals("async_rst");
      @(posedge clock);
      @(negedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = '0;
      #2 check_reset_vals("por");
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Default ratio 1: clk_en every cycle, div_clk at clock/2.
      run(3);
      measure_period("def_div1", 20);

      // Ratio 4 loaded in IDLE, then enabled.
      cyc(1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, '0);
      cyc(1'b0, 1'b1, 8'd4);
      run(2);
      measure_period("div4", 80);

      // Ratio change 4 -> 3 offered one cycle into a period.
      wait_clk_en("sw43");
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      cyc(1'b1, 1'b1, 8'd3);
      cyc(1'b1, 1'b1, 8'd3);  // offered again while a change is pending
      run(14);

      // Zero ratio in RUN.
      cyc(1'b1, 1'b1, 8'd0);
      run(12);

      // Ratio 5, enable dropped on a clk_en cycle.
      cyc(1'b1, 1'b1, 8'd5);
      run(12);
      wait_clk_en("drop5");
      #1 enable = 1'b0;
      @(posedge clock);
      #1;
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, '0);

      // Same-edge ratio load and enable, then reset while a switch is pending.
      cyc(1'b1, 1'b1, 8'd6);
      run(2);
      cyc(1'b1, 1'b1, 8'd7);
      cyc(1'b1, 1'b0, '0);
      reset_pulse();
      run(6);

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 119) == 0) begin
            reset_pulse();
         end else begin
            cyc(($urandom_range(0, 15) != 0),
                ($urandom_range(0, 3) == 0),
                W'($urandom_range(0, 7)));
         end
      end

      cyc(1'b0, 1'b0, '0);
      repeat (2) @(negedge clock);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
